mppt_adc_sampler: RTL and testbench

- SPI master for a 2-channel, 12-bit SAR ADC with an MCP3202-style protocol.
- Alternately converts panel voltage (CH0) and panel current (CH1), then publishes the pair as 12-bit V and I words with a one-cycle valid strobe.
- Sits directly upstream of the MPPT tracker and drives its V and I inputs.
- Optionally averages several pairs before publishing.

---
 rtl/mppt_adc_sampler.sv | 228 ++++++++++++++++++++++
 tb/tb_mppt_adc_sampler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mppt_adc_sampler.sv
// SPI master for a 2-channel 12-bit SAR ADC (MCP3202-style): converts panel voltage then current
// and publishes the pair. Define MPPT_ADC_AVG_EN to average 2^AVG_LOG2 pairs before publishing.
module mppt_adc_sampler #(
   parameter int CLK_DIV    = 4,
   parameter int SAMPLE_GAP = 64
`ifdef MPPT_ADC_AVG_EN
   ,
   parameter int AVG_LOG2   = 2
`endif
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        enable,
   output logic        adc_cs_n,
   output logic        adc_sclk,
   output logic        adc_mosi,
   input  logic        adc_miso,
   output logic [11:0] v_out,
   output logic [11:0] i_out,
   output logic        sample_valid,
   output logic        busy
);

   // SAMPLE_GAP is expected to be at least 1; the counter is shared by every timed state.
   localparam int CNT_MAX = (CLK_DIV > SAMPLE_GAP) ? CLK_DIV : SAMPLE_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(SAMPLE_GAP - 1);
   localparam logic [4:0]       FIRST_DATA = 5'd5;
   localparam logic [4:0]       LAST_BIT   = 5'd16;

   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [4:0]       bit_cnt_r;
   logic             chan_r;
   logic             miso_meta_r;
   logic             miso_sync_r;
   logic [10:0]      shift_r;
   logic [11:0]      v_data_r;
   logic [11:0]      word_s;

   assign word_s = {shift_r, miso_sync_r};

`ifdef MPPT_ADC_AVG_EN
   localparam int ACC_W = 12 + AVG_LOG2;
   localparam logic [AVG_LOG2-1:0] PAIR_LAST = {AVG_LOG2{1'b1}};
   localparam logic [AVG_LOG2-1:0] PAIR_ONE  = AVG_LOG2'(1);
   logic [ACC_W-1:0]    acc_v_r;
   logic [ACC_W-1:0]    acc_i_r;
   logic [ACC_W-1:0]    sum_v_s;
   logic [ACC_W-1:0]    sum_i_s;
   logic [AVG_LOG2-1:0] pair_cnt_r;

   assign sum_v_s = acc_v_r + ACC_W'(v_data_r);
   assign sum_i_s = acc_i_r + ACC_W'(word_s);
`endif

   // Command bit presented before rising edge idx+1: START, SGL, ODD=channel, MSBF, then zeros.
   function automatic logic cmd_bit(input logic chan, input logic [4:0] idx);
      logic b;
      case (idx)
         5'd0, 5'd1, 5'd3: b = 1'b1;
         5'd2:             b = chan;
         default:          b = 1'b0;
      endcase
      return b;
   endfunction

   // Two-flop synchroniser for the ADC data line
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         miso_meta_r <= 1'b0;
         miso_sync_r <= 1'b0;
      end else begin
         miso_meta_r <= adc_miso;
         miso_sync_r <= miso_meta_r;
      end
   end

   // Frame sequencer: SPI timing, data capture and publishing of the V/I pair
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_r      <= ST_IDLE;
         cnt_r        <= CNT_ZERO;
         bit_cnt_r    <= 5'd0;
         chan_r       <= 1'b0;
         shift_r      <= 11'd0;
         v_data_r     <= 12'd0;
         adc_cs_n     <= 1'b1;
         adc_sclk     <= 1'b0;
         adc_mosi     <= 1'b0;
         v_out        <= 12'd0;
         i_out        <= 12'd0;
         sample_valid <= 1'b0;
         busy         <= 1'b0;
`ifdef MPPT_ADC_AVG_EN
         acc_v_r      <= {ACC_W{1'b0}};
         acc_i_r      <= {ACC_W{1'b0}};
         pair_cnt_r   <= {AVG_LOG2{1'b0}};
`endif
      end else begin
         sample_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (enable) begin
                  state_r  <= ST_SETUP;
                  chan_r   <= 1'b0;
                  cnt_r    <= CNT_ZERO;
                  adc_cs_n <= 1'b0;
                  adc_mosi <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (cnt_r == DIV_LAST) begin
                  state_r   <= ST_SHIFT;
                  cnt_r     <= CNT_ZERO;
                  bit_cnt_r <= 5'd0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_SHIFT: begin
               if (cnt_r != DIV_LAST) begin
                  cnt_r <= cnt_r + CNT_ONE;
               end else if (!adc_sclk) begin
                  cnt_r    <= CNT_ZERO;
                  adc_sclk <= 1'b1;
               end else begin
                  // Data is taken at the end of the high phase so the synchroniser has settled.
                  cnt_r    <= CNT_ZERO;
                  adc_sclk <= 1'b0;
                  if (bit_cnt_r == LAST_BIT) begin
                     state_r  <= ST_HOLD;
                     adc_cs_n <= 1'b1;
                     adc_mosi <= 1'b0;
                     if (!chan_r) begin
                        v_data_r <= word_s;
                     end else begin
`ifdef MPPT_ADC_AVG_EN
                        if (pair_cnt_r == PAIR_LAST) begin
                           v_out        <= sum_v_s[ACC_W-1:AVG_LOG2];
                           i_out        <= sum_i_s[ACC_W-1:AVG_LOG2];
                           sample_valid <= 1'b1;
                           acc_v_r      <= {ACC_W{1'b0}};
                           acc_i_r      <= {ACC_W{1'b0}};
                           pair_cnt_r   <= {AVG_LOG2{1'b0}};
                        end else begin
                           acc_v_r    <= sum_v_s;
                           acc_i_r    <= sum_i_s;
                           pair_cnt_r <= pair_cnt_r + PAIR_ONE;
                        end
`else
                        v_out        <= v_data_r;
                        i_out        <= word_s;
                        sample_valid <= 1'b1;
`endif
                     end
                  end else begin
                     if (bit_cnt_r >= FIRST_DATA) begin
                        shift_r <= {shift_r[9:0], miso_sync_r};
                     end
                     bit_cnt_r <= bit_cnt_r + 5'd1;
                     adc_mosi  <= cmd_bit(chan_r, bit_cnt_r + 5'd1);
                  end
               end
            end
            ST_HOLD: begin
               if (cnt_r != DIV_LAST) begin
                  cnt_r <= cnt_r + CNT_ONE;
               end else begin
                  cnt_r <= CNT_ZERO;
                  if (!chan_r) begin
                     state_r  <= ST_SETUP;
                     chan_r   <= 1'b1;
                     adc_cs_n <= 1'b0;
                     adc_mosi <= 1'b1;
                  end else if (enable) begin
                     state_r <= ST_GAP;
                  end else begin
                     state_r <= ST_IDLE;
                     busy    <= 1'b0;
`ifdef MPPT_ADC_AVG_EN
                     acc_v_r    <= {ACC_W{1'b0}};
                     acc_i_r    <= {ACC_W{1'b0}};
                     pair_cnt_r <= {AVG_LOG2{1'b0}};
`endif
                  end
               end
            end
            ST_GAP: begin
               if (cnt_r != GAP_LAST) begin
                  cnt_r <= cnt_r + CNT_ONE;
               end else begin
                  cnt_r <= CNT_ZERO;
                  if (enable) begin
                     state_r  <= ST_SETUP;
                     chan_r   <= 1'b0;
                     adc_cs_n <= 1'b0;
                     adc_mosi <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                     busy    <= 1'b0;
`ifdef MPPT_ADC_AVG_EN
                     acc_v_r    <= {ACC_W{1'b0}};
                     acc_i_r    <= {ACC_W{1'b0}};
                     pair_cnt_r <= {AVG_LOG2{1'b0}};
`endif
                  end
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               cnt_r    <= CNT_ZERO;
               adc_cs_n <= 1'b1;
               adc_sclk <= 1'b0;
               adc_mosi <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mppt_adc_sampler.sv
// Self-checking bench for mppt_adc_sampler: behavioural MCP3202 model, scoreboard of expected
// V/I pairs, and directed steps for latency, continuous run, enable drop, reset and code limits.
module tb_mppt_adc_sampler;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        enable   = 1'b0;
   logic        adc_miso = 1'b0;
   logic        adc_cs_n;
   logic        adc_sclk;
   logic        adc_mosi;
   logic [11:0] v_out;
   logic [11:0] i_out;
   logic        sample_valid;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [11:0] adc_v_code = 12'd0;
   logic [11:0] adc_i_code = 12'd0;
   int          m_edges = 0;
   logic [3:0]  m_cmd = 4'b0000;
   logic [11:0] m_word;

   logic [23:0] exp_q[$];
   int          fr_cnt = 0;
   int          rises = 0;
   int          last_rise = 0;
   int          fall_total = 0;
   int          valid_total = 0;
   int          v_fall_cyc = 0;
   logic        prev_cs = 1'b1;
   logic        prev_sclk = 1'b0;
   logic        prev_valid = 1'b0;
   logic [3:0]  exp_cmd = 4'b1101;
   logic [23:0] e;

   mppt_adc_sampler dut (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_i     (wb_rst_i),
      .enable       (enable),
      .adc_cs_n     (adc_cs_n),
      .adc_sclk     (adc_sclk),
      .adc_mosi     (adc_mosi),
      .adc_miso     (adc_miso),
      .v_out        (v_out),
      .i_out        (i_out),
      .sample_valid (sample_valid),
      .busy         (busy)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   initial forever begin
      @(posedge wb_clk_i);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ADC model: decodes the command on rising edges, shifts data out on falling edges
   initial forever begin
      @(negedge adc_cs_n);
      m_edges = 0;
      m_cmd   = 4'b0000;
   end

   initial forever begin
      @(posedge adc_sclk);
      if (!adc_cs_n) begin
         m_edges++;
         if (m_edges <= 4) m_cmd = {m_cmd[2:0], adc_mosi};
      end
   end

   initial forever begin
      @(negedge adc_sclk);
      m_word = m_cmd[1] ? adc_i_code : adc_v_code;
      if (!adc_cs_n && m_edges >= 5 && m_edges <= 16) adc_miso = m_word[16 - m_edges];
      else adc_miso = 1'b0;
   end

   // Monitor: frame shape, command bits and scoreboard comparison on each strobe
   initial forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
         fr_cnt     = 0;
         rises      = 0;
         prev_cs    = 1'b1;
         prev_sclk  = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (prev_cs && !adc_cs_n) begin
            exp_cmd = fr_cnt[0] ? 4'b1111 : 4'b1101;
            if (!fr_cnt[0]) v_fall_cyc = cyc;
            fr_cnt++;
            fall_total++;
            rises = 0;
         end
         if (!prev_sclk && adc_sclk) begin
            if (rises > 0) chk("sclk_period", cyc - last_rise, 8);
            chk("mosi_bit", adc_mosi, (rises < 4) ? exp_cmd[3 - rises] : 1'b0);
            last_rise = cyc;
            rises++;
         end
         if (!prev_cs && adc_cs_n) chk("sclk_count", rises, 17);
         if (sample_valid) begin
            valid_total++;
            chk("valid_single_cycle", prev_valid, 1'b0);
            chk("sb_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("v_out", v_out, e[23:12]);
               chk("i_out", i_out, e[11:0]);
            end
         end
         prev_cs    = adc_cs_n;
         prev_sclk  = adc_sclk;
         prev_valid = sample_valid;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge wb_clk_i);
   endtask

   task automatic pulse_enable();
      @(negedge wb_clk_i);
      enable = 1'b1;
      @(negedge wb_clk_i);
      enable = 1'b0;
   endtask

   task automatic wait_valid(output int c);
      int n;
      n = 0;
      c = -1;
      while (n < 1500) begin
         @(negedge wb_clk_i);
         n++;
         if (sample_valid) begin
            c = cyc;
            break;
         end
      end
      chk("valid_timeout", c >= 0, 1'b1);
   endtask

   task automatic wait_falls(input int target);
      int n;
      n = 0;
      while (fall_total < target && n < 1500) begin
         @(negedge wb_clk_i);
         n++;
      end
      chk("fall_timeout", fall_total >= target, 1'b1);
   endtask

   initial begin
      int c0, c1, c2, t0, f0, v0, n;

      tick(3);
      chk("rst_cs_n", adc_cs_n, 1'b1);
      chk("rst_sclk", adc_sclk, 1'b0);
      chk("rst_mosi", adc_mosi, 1'b0);
      chk("rst_v_out", v_out, 12'd0);
      chk("rst_i_out", i_out, 12'd0);
      chk("rst_valid", sample_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      #2 wb_rst_i = 1'b0;
      tick(2);

`ifdef MPPT_ADC_AVG_EN
      f0 = fall_total;
      v0 = valid_total;
      exp_q.push_back({12'd250, 12'd25});
      adc_v_code = 12'd100;
      adc_i_code = 12'd10;
      enable = 1'b1;
      wait_falls(f0 + 3);
      adc_v_code = 12'd200;
      adc_i_code = 12'd20;
      wait_falls(f0 + 5);
      adc_v_code = 12'd300;
      adc_i_code = 12'd30;
      wait_falls(f0 + 7);
      adc_v_code = 12'd401;
      adc_i_code = 12'd41;
      wait_valid(c0);
      tick(1);
      chk("avg_single_valid", valid_total - v0, 1);
      exp_q.push_back({12'hFFF, 12'hFFF});
      adc_v_code = 12'hFFF;
      adc_i_code = 12'hFFF;
      wait_valid(c1);
      enable = 1'b0;
      tick(100);
      chk("avg_valid_total", valid_total - v0, 2);
      chk("avg_idle_busy", busy, 1'b0);
`else
      // Single pair from a one-cycle enable pulse
      f0 = fall_total;
      adc_v_code = 12'hA5C;
      adc_i_code = 12'h3F1;
      exp_q.push_back({12'hA5C, 12'h3F1});
      pulse_enable();
      tick(10);
      chk("sp_busy_run", busy, 1'b1);
      wait_valid(c0);
      chk("sp_latency", c0 - v_fall_cyc, 284);
      tick(150);
      chk("sp_idle_busy", busy, 1'b0);
      chk("sp_idle_cs_n", adc_cs_n, 1'b1);
      chk("sp_frames", fall_total - f0, 2);

      // Continuous run of three pairs with different codes
      adc_v_code = 12'h123;
      adc_i_code = 12'h456;
      exp_q.push_back({12'h123, 12'h456});
      @(negedge wb_clk_i);
      enable = 1'b1;
      wait_valid(c0);
      t0 = v_fall_cyc;
      chk("cont_pair0", c0 - t0, 284);
      adc_v_code = 12'h7FF;
      adc_i_code = 12'h800;
      exp_q.push_back({12'h7FF, 12'h800});
      wait_valid(c1);
      chk("cont_pair1", c1 - t0, 636);
      adc_v_code = 12'h001;
      adc_i_code = 12'hFFE;
      exp_q.push_back({12'h001, 12'hFFE});
      wait_valid(c2);
      chk("cont_pair2", c2 - t0, 988);
      enable = 1'b0;
      tick(100);
      chk("cont_idle_busy", busy, 1'b0);

      // Enable dropped during the V frame: the pair still completes
      f0 = fall_total;
      adc_v_code = 12'h5A5;
      adc_i_code = 12'h0F0;
      exp_q.push_back({12'h5A5, 12'h0F0});
      enable = 1'b1;
      wait_falls(f0 + 1);
      tick(20);
      enable = 1'b0;
      wait_valid(c0);
      chk("drop_latency", c0 - v_fall_cyc, 284);
      tick(150);
      chk("drop_busy", busy, 1'b0);
      chk("drop_cs_n", adc_cs_n, 1'b1);
      chk("drop_frames", fall_total - f0, 2);

      // Boundary codes
      adc_v_code = 12'hFFF;
      adc_i_code = 12'h000;
      exp_q.push_back({12'hFFF, 12'h000});
      pulse_enable();
      wait_valid(c0);
      tick(10);
      adc_v_code = 12'h000;
      adc_i_code = 12'hFFF;
      exp_q.push_back({12'h000, 12'hFFF});
      pulse_enable();
      wait_valid(c0);
      tick(10);

      // Reset in the middle of the I frame shift
      f0 = fall_total;
      adc_v_code = 12'h321;
      adc_i_code = 12'hCDE;
      exp_q.push_back({12'h321, 12'hCDE});
      enable = 1'b1;
      n = 0;
      while (!(fall_total >= f0 + 2 && rises >= 9) && n < 1500) begin
         @(negedge wb_clk_i);
         n++;
      end
      chk("rst_wait_timeout", n < 1500, 1'b1);
      #2 wb_rst_i = 1'b1;
      #1;
      chk("mid_rst_cs_n", adc_cs_n, 1'b1);
      chk("mid_rst_sclk", adc_sclk, 1'b0);
      chk("mid_rst_v_out", v_out, 12'd0);
      chk("mid_rst_i_out", i_out, 12'd0);
      chk("mid_rst_busy", busy, 1'b0);
      exp_q.delete();
      adc_v_code = 12'h654;
      adc_i_code = 12'h987;
      exp_q.push_back({12'h654, 12'h987});
      tick(2);
      #2 wb_rst_i = 1'b0;
      wait_valid(c0);
      chk("post_rst_latency", c0 - v_fall_cyc, 284);
      enable = 1'b0;
      tick(100);
      chk("post_rst_busy", busy, 1'b0);
`endif

      chk("sb_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
